// File: rtl/pipeline_sequencer_if.sv
// Handshake bundle between decode/control (master) and the pipeline sequencer (slave).
// Carries decoded register usage, EX resolution, and the pipeline-register controls.
interface pipeline_sequencer_if #(
  parameter int unsigned REG_W = 4
);
  logic             id_valid;
  logic [REG_W-1:0] id_rs1;
  logic [REG_W-1:0] id_rs2;
  logic             id_rs1_used;
  logic             id_rs2_used;
  logic [REG_W-1:0] id_rd;
  logic             id_reg_write;
  logic             id_write_op2;
  logic             id_halt;
  logic             ex_branch_taken;
  logic             ex_jump;
  logic             ex_overflow;

  logic             pc_we;
  logic             ifid_we;
  logic             ifid_flush;
  logic             idex_bubble;
  logic             exmem_kill;
  logic             halted;
  logic [15:0]      stall_cycles;

  modport master (
    output id_valid, id_rs1, id_rs2, id_rs1_used, id_rs2_used, id_rd,
           id_reg_write, id_write_op2, id_halt,
           ex_branch_taken, ex_jump, ex_overflow,
    input  pc_we, ifid_we, ifid_flush, idex_bubble, exmem_kill, halted, stall_cycles
  );

  modport slave (
    input  id_valid, id_rs1, id_rs2, id_rs1_used, id_rs2_used, id_rd,
           id_reg_write, id_write_op2, id_halt,
           ex_branch_taken, ex_jump, ex_overflow,
    output pc_we, ifid_we, ifid_flush, idex_bubble, exmem_kill, halted, stall_cycles
  );
endinterface

// File: rtl/pipeline_sequencer.sv
// Pipeline sequencing controller: 3-slot writeback scoreboard for RAW stalls,
// branch/jump flushes, and a RUN/DRAIN/HALTED machine for halt and ALU overflow.
module pipeline_sequencer #(
  parameter int unsigned REG_W        = 4,
  parameter int unsigned DRAIN_CYCLES = 3
) (
  input logic                 clk,
  input logic                 rst,
  pipeline_sequencer_if.slave bus
);

  localparam int unsigned CNT_W = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;

  typedef enum logic [1:0] {
    ST_RUN,
    ST_DRAIN,
    ST_HALTED
  } state_t;

  typedef struct packed {
    logic             a_en;
    logic [REG_W-1:0] a_addr;
    logic             b_en;
    logic [REG_W-1:0] b_addr;
  } slot_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [15:0]      stall_q, stall_d;
  slot_t            sb_q [3];
  slot_t            s0_d;

  logic rs1_hit, rs2_hit, hazard;
  logic pc_we, ifid_we, ifid_flush, idex_bubble, exmem_kill;

  // No forwarding: a source matching any in-flight destination must wait for writeback.
  always_comb begin
    rs1_hit = 1'b0;
    rs2_hit = 1'b0;
    for (int unsigned i = 0; i < 3; i++) begin
      if ((sb_q[i].a_en && sb_q[i].a_addr == bus.id_rs1) ||
          (sb_q[i].b_en && sb_q[i].b_addr == bus.id_rs1)) rs1_hit = 1'b1;
      if ((sb_q[i].a_en && sb_q[i].a_addr == bus.id_rs2) ||
          (sb_q[i].b_en && sb_q[i].b_addr == bus.id_rs2)) rs2_hit = 1'b1;
    end
    hazard = bus.id_valid &
             ((bus.id_rs1_used & rs1_hit) | (bus.id_rs2_used & rs2_hit));
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    stall_d     = stall_q;
    s0_d        = '0;
    pc_we       = 1'b0;
    ifid_we     = 1'b0;
    ifid_flush  = 1'b0;
    idex_bubble = 1'b0;
    exmem_kill  = 1'b0;

    case (state_q)
      ST_RUN: begin
        if (bus.ex_overflow) begin
          exmem_kill  = 1'b1;
          ifid_flush  = 1'b1;
          idex_bubble = 1'b1;
          state_d     = ST_DRAIN;
          cnt_d       = CNT_W'(DRAIN_CYCLES - 1);
        end else if (bus.ex_branch_taken || bus.ex_jump) begin
          pc_we       = 1'b1;
          ifid_flush  = 1'b1;
          idex_bubble = 1'b1;
        end else if (hazard) begin
          idex_bubble = 1'b1;
          if (stall_q != '1) stall_d = stall_q + 16'd1;
        end else if (bus.id_valid && bus.id_halt) begin
          // The halt itself issues but carries no register writes.
          state_d = ST_DRAIN;
          cnt_d   = CNT_W'(DRAIN_CYCLES - 1);
        end else begin
          pc_we   = 1'b1;
          ifid_we = 1'b1;
          if (bus.id_valid) begin
            s0_d.a_en   = bus.id_reg_write;
            s0_d.a_addr = bus.id_rd;
            s0_d.b_en   = bus.id_write_op2;
            s0_d.b_addr = bus.id_rs2;
          end
        end
      end

      ST_DRAIN: begin
        idex_bubble = 1'b1;
        exmem_kill  = bus.ex_overflow;
        if (cnt_q == '0) state_d = ST_HALTED;
        else             cnt_d   = cnt_q - CNT_W'(1);
      end

      ST_HALTED: begin
        idex_bubble = 1'b1;
      end

      default: begin
        state_d = ST_RUN;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_RUN;
      cnt_q   <= '0;
      stall_q <= '0;
      for (int unsigned i = 0; i < 3; i++) sb_q[i] <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      stall_q <= stall_d;
      sb_q[0] <= s0_d;
      sb_q[1] <= sb_q[0];
      sb_q[2] <= sb_q[1];
    end
  end

  assign bus.pc_we        = pc_we;
  assign bus.ifid_we      = ifid_we;
  assign bus.ifid_flush   = ifid_flush;
  assign bus.idex_bubble  = idex_bubble;
  assign bus.exmem_kill   = exmem_kill;
  assign bus.halted       = (state_q == ST_HALTED);
  assign bus.stall_cycles = stall_q;

endmodule

// File: tb/tb_pipeline_sequencer.sv
// Self-checking bench for pipeline_sequencer: directed scenarios followed by
// random traffic, all compared against a register-bitmask reference model.
module tb_pipeline_sequencer;

  localparam int unsigned REG_W        = 4;
  localparam int unsigned DRAIN_CYCLES = 3;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  pipeline_sequencer_if #(.REG_W(REG_W)) bus();

  pipeline_sequencer #(
    .REG_W       (REG_W),
    .DRAIN_CYCLES(DRAIN_CYCLES)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus.slave)
  );

  int checks = 0;
  int errors = 0;

  // Reference model: mode 0=running, 1=draining, 2=halted.
  int          m_mode;
  int          m_left;
  int          m_stalls;
  logic [15:0] m_hist[$];   // register-write masks of the last three issue slots

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_mode   = 0;
    m_left   = 0;
    m_stalls = 0;
    m_hist   = {16'h0, 16'h0, 16'h0};
  endtask

  task automatic idle();
    bus.id_valid = 0; bus.id_rs1 = '0; bus.id_rs2 = '0;
    bus.id_rs1_used = 0; bus.id_rs2_used = 0; bus.id_rd = '0;
    bus.id_reg_write = 0; bus.id_write_op2 = 0; bus.id_halt = 0;
    bus.ex_branch_taken = 0; bus.ex_jump = 0; bus.ex_overflow = 0;
  endtask

  task automatic set_id(input logic v, input logic [3:0] rs1, input logic u1,
                        input logic [3:0] rs2, input logic u2, input logic [3:0] rd,
                        input logic rw, input logic wop2, input logic halt);
    bus.id_valid = v; bus.id_rs1 = rs1; bus.id_rs1_used = u1;
    bus.id_rs2 = rs2; bus.id_rs2_used = u2; bus.id_rd = rd;
    bus.id_reg_write = rw; bus.id_write_op2 = wop2; bus.id_halt = halt;
  endtask

  // One clock: check outputs against the model before the edge, then advance the model.
  task automatic cycle();
    logic        e_pc, e_ifid, e_flush, e_bub, e_kill, hz;
    logic [15:0] busy, push;
    int          n_mode, n_left, n_stalls;
    @(negedge clk);
    e_pc = 0; e_ifid = 0; e_flush = 0; e_bub = 0; e_kill = 0;
    push = '0;
    n_mode = m_mode; n_left = m_left; n_stalls = m_stalls;
    busy = m_hist[0] | m_hist[1] | m_hist[2];
    hz = bus.id_valid & ((bus.id_rs1_used & busy[bus.id_rs1]) |
                         (bus.id_rs2_used & busy[bus.id_rs2]));
    if (m_mode == 0) begin
      if (bus.ex_overflow) begin
        e_kill = 1; e_flush = 1; e_bub = 1;
        n_mode = 1; n_left = DRAIN_CYCLES;
      end else if (bus.ex_branch_taken | bus.ex_jump) begin
        e_pc = 1; e_flush = 1; e_bub = 1;
      end else if (hz) begin
        e_bub = 1;
        if (m_stalls < 65535) n_stalls = m_stalls + 1;
      end else if (bus.id_valid & bus.id_halt) begin
        n_mode = 1; n_left = DRAIN_CYCLES;
      end else begin
        e_pc = 1; e_ifid = 1;
        if (bus.id_valid) begin
          if (bus.id_reg_write) push[bus.id_rd]  = 1'b1;
          if (bus.id_write_op2) push[bus.id_rs2] = 1'b1;
        end
      end
    end else if (m_mode == 1) begin
      e_bub = 1; e_kill = bus.ex_overflow;
      n_left = m_left - 1;
      if (n_left == 0) n_mode = 2;
    end else begin
      e_bub = 1;
    end
    if (!rst) begin
      chk("pc_we",        16'(bus.pc_we),       16'(e_pc));
      chk("ifid_we",      16'(bus.ifid_we),     16'(e_ifid));
      chk("ifid_flush",   16'(bus.ifid_flush),  16'(e_flush));
      chk("idex_bubble",  16'(bus.idex_bubble), 16'(e_bub));
      chk("exmem_kill",   16'(bus.exmem_kill),  16'(e_kill));
      chk("halted",       16'(bus.halted),      16'(m_mode == 2));
      chk("stall_cycles", bus.stall_cycles,     16'(m_stalls));
    end
    @(posedge clk);
    #1;
    if (rst) begin
      model_reset();
    end else begin
      void'(m_hist.pop_front());
      m_hist.push_back(push);
      m_mode = n_mode; m_left = n_left; m_stalls = n_stalls;
    end
  endtask

  initial begin
    int base;
    model_reset();
    idle();
    rst = 1;
    cycle(); cycle();
    rst = 0;
    #1;
    chk("reset_pc_we",   16'(bus.pc_we),   16'd1);
    chk("reset_ifid_we", 16'(bus.ifid_we), 16'd1);
    chk("reset_stall",   bus.stall_cycles, 16'd0);
    chk("reset_halted",  16'(bus.halted),  16'd0);

    // Independent operands stream without stalls.
    for (int i = 0; i < 6; i++) begin
      set_id(1, 4'd1, 1, 4'd2, 1, 4'(8 + i), 1, 0, 0);
      cycle();
    end
    chk("indep_no_stall", bus.stall_cycles, 16'd0);
    idle(); cycle(); cycle(); cycle();

    // RegWrite producer of R3 followed by a reader of R3.
    base = int'(bus.stall_cycles);
    set_id(1, 4'd0, 0, 4'd0, 0, 4'd3, 1, 0, 0); cycle();
    set_id(1, 4'd3, 1, 4'd0, 0, 4'd9, 1, 0, 0);
    for (int i = 0; i < 3; i++) begin
      #1; chk("raw_stall_pc_we", 16'(bus.pc_we), 16'd0);
      cycle();
    end
    #1; chk("raw_issue_pc_we", 16'(bus.pc_we), 16'd1);
    cycle();
    chk("raw_stall_count", bus.stall_cycles, 16'(base + 3));
    idle(); cycle(); cycle(); cycle();

    // WriteOP2 producer of R5 followed by a reader of R5.
    base = int'(bus.stall_cycles);
    set_id(1, 4'd0, 0, 4'd5, 0, 4'd6, 0, 1, 0); cycle();
    set_id(1, 4'd0, 0, 4'd5, 1, 4'd7, 0, 0, 0);
    cycle(); cycle(); cycle(); cycle();
    chk("wop2_stall_count", bus.stall_cycles, 16'(base + 3));
    idle(); cycle(); cycle(); cycle();

    // Reader of a register nobody writes does not stall.
    base = int'(bus.stall_cycles);
    set_id(1, 4'd0, 0, 4'd5, 0, 4'd6, 1, 1, 0); cycle();
    set_id(1, 4'd11, 1, 4'd12, 1, 4'd0, 0, 0, 0); cycle();
    chk("unwritten_no_stall", bus.stall_cycles, 16'(base));
    idle(); cycle(); cycle(); cycle();

    // Jump discards a halt sitting in ID.
    set_id(1, 4'd0, 0, 4'd0, 0, 4'd0, 0, 0, 1);
    bus.ex_jump = 1;
    #1;
    chk("jump_flush",  16'(bus.ifid_flush),  16'd1);
    chk("jump_bubble", 16'(bus.idex_bubble), 16'd1);
    chk("jump_pc_we",  16'(bus.pc_we),       16'd1);
    cycle();
    idle(); #1;
    chk("jump_stays_run", 16'(bus.pc_we), 16'd1);
    cycle();

    // Halt drains for DRAIN_CYCLES then halts.
    set_id(1, 4'd0, 0, 4'd0, 0, 4'd0, 0, 0, 1); cycle();
    idle();
    cycle(); cycle();
    chk("halt_not_yet", 16'(bus.halted), 16'd0);
    cycle();
    chk("halt_reached", 16'(bus.halted), 16'd1);
    cycle();
    rst = 1; cycle(); rst = 0;

    // Reset in the middle of DRAIN.
    set_id(1, 4'd0, 0, 4'd0, 0, 4'd0, 0, 0, 1); cycle();
    idle(); cycle();
    rst = 1; cycle(); rst = 0;
    #1;
    chk("mid_drain_reset_pc_we", 16'(bus.pc_we), 16'd1);
    cycle();

    // Overflow wins over a pending hazard.
    set_id(1, 4'd0, 0, 4'd0, 0, 4'd4, 1, 0, 0); cycle();
    base = int'(bus.stall_cycles);
    set_id(1, 4'd4, 1, 4'd0, 0, 4'd1, 1, 0, 0);
    bus.ex_overflow = 1;
    #1;
    chk("ovf_kill",  16'(bus.exmem_kill), 16'd1);
    chk("ovf_flush", 16'(bus.ifid_flush), 16'd1);
    cycle();
    idle();
    cycle(); cycle(); cycle();
    chk("ovf_halted", 16'(bus.halted), 16'd1);
    chk("ovf_stall_unchanged", bus.stall_cycles, 16'(base));
    rst = 1; cycle(); rst = 0;

    // Random traffic.
    for (int n = 0; n < 3000; n++) begin
      set_id(1'($urandom_range(7, 0) != 0),
             4'($urandom_range(15, 0)), 1'($urandom_range(1, 0)),
             4'($urandom_range(15, 0)), 1'($urandom_range(1, 0)),
             4'($urandom_range(15, 0)), 1'($urandom_range(1, 0)),
             1'($urandom_range(3, 0) == 0), 1'($urandom_range(29, 0) == 0));
      bus.ex_branch_taken = 1'($urandom_range(11, 0) == 0);
      bus.ex_jump         = 1'($urandom_range(15, 0) == 0);
      bus.ex_overflow     = 1'($urandom_range(49, 0) == 0);
      rst = ((m_mode == 2) && ($urandom_range(3, 0) == 0)) || ($urandom_range(299, 0) == 0);
      cycle();
    end
    rst = 0;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/pipeline_sequencer.md
# pipeline_sequencer

Central sequencing controller for the 5-stage pipelined datapath. It sits beside the decode stage and control unit, and turns decoded register usage, write-enables (RegWrite, WriteOP2), Halt, branch/jump resolution and ALU overflow into pipeline-register enables, flushes and bubbles. A 3-slot writeback scoreboard detects read-after-write hazards. A RUN/DRAIN/HALTED state machine empties the pipeline on halt or overflow.

## Interface
- REG_W, 4, register-address width (16 registers)
- DRAIN_CYCLES, 3, cycles spent in DRAIN before HALTED (EX, MEM, WB)
- clk  in  1  rising-edge clock
- rst  in  1  reset, synchronous, active-high
- id_valid  in  1  ID stage holds a real instruction
- id_rs1, id_rs2  in  REG_W  source register addresses
- id_rs1_used, id_rs2_used  in  1  the instruction reads that source
- id_rd  in  REG_W  primary destination
- id_reg_write  in  1  writes id_rd (RegWrite)
- id_write_op2  in  1  also writes id_rs2 as second result (WriteOP2)
- id_halt  in  1  Halt decoded in ID
- ex_branch_taken, ex_jump  in  1  redirect resolved in EX
- ex_overflow  in  1  ALU overflow on the instruction in EX
- pc_we  out  1  PC register load enable
- ifid_we  out  1  IF/ID register load enable
- ifid_flush  out  1  clear IF/ID to NOP
- idex_bubble  out  1  load NOP into ID/EX
- exmem_kill  out  1  suppress RegWrite/WriteOP2 of the instruction leaving EX
- halted  out  1  state == HALTED
- stall_cycles  out  16  saturating count of hazard-stall cycles

## Operation
- States: RUN, DRAIN, HALTED. rst forces RUN, clears all scoreboard slots, and sets drain counter and stall_cycles to 0.
- Scoreboard: slots S0 (ID/EX), S1 (EX/MEM), S2 (MEM/WB). Each slot holds {a_en, a_addr, b_en, b_addr}. Every cycle S2<=S1, S1<=S0. S0 loads {id_reg_write, id_rd, id_write_op2, id_rs2} when the ID instruction issues. Otherwise S0 loads all-zero (bubble). R0 is not special.
- hazard = id_valid & ((id_rs1_used & match(id_rs1)) | (id_rs2_used & match(id_rs2))). match(r) is true when any slot has a_en&&a_addr==r or b_en&&b_addr==r. The register file has no forwarding.
- In RUN, conditions are evaluated in priority order; the first true one applies:
  1. ex_overflow: exmem_kill=1, ifid_flush=1, idex_bubble=1, pc_we=0, ifid_we=0. Next state is DRAIN with counter=DRAIN_CYCLES-1.
  2. ex_branch_taken|ex_jump: pc_we=1, ifid_flush=1, idex_bubble=1. The ID instruction (including any halt) is discarded.
  3. hazard: pc_we=0, ifid_we=0, idex_bubble=1. stall_cycles += 1, saturating at 0xFFFF.
  4. id_valid&id_halt: the halt issues into S0 with no writes. pc_we=0, ifid_we=0. Next state is DRAIN with counter=DRAIN_CYCLES-1.
  5. Otherwise (normal): pc_we=1, ifid_we=1, and the ID instruction issues.
- DRAIN: pc_we=0, ifid_we=0, idex_bubble=1. Branch, jump, halt and hazard inputs are ignored; older instructions have already passed EX. ex_overflow in DRAIN still asserts exmem_kill. The counter decrements each cycle, and the state moves to HALTED on the cycle the counter is 0.
- HALTED: pc_we=0, ifid_we=0, idex_bubble=1, halted=1. Only rst leaves this state.
- Bubble and flush outputs never load S0 with writes.

## Timing
- Outputs are combinational (Mealy) from the current state, the scoreboard and the current inputs. State, scoreboard and counters update on the rising clk edge.
- Reset values with idle inputs, in the cycle after rst: pc_we=1, ifid_we=1, ifid_flush=0, idex_bubble=0, exmem_kill=0, halted=0, stall_cycles=0.
- rst asserted in any state, including mid-DRAIN or mid-stall, takes effect at the next edge and overrides all inputs.
- Producer-to-consumer stall: a dependent instruction directly behind its producer stalls 3 cycles. It issues when the producer leaves S2, i.e. once writeback has completed.
- A branch redirect costs 2 cycles: the IF/ID and ID/EX contents are flushed.
- Halt in ID leads to halted=1 exactly DRAIN_CYCLES+1 cycles later (4 by default).

## Test plan
- Reset, then id_valid=1 with independent operands -> pc_we=ifid_we=1 every cycle and stall_cycles=0.
- Issue R3 write, then next cycle ID reads rs1=3 -> 3 cycles with pc_we=0, idex_bubble=1; issue on the 4th cycle; stall_cycles=3.
- WriteOP2 producer (rs2=5) followed by a reader of R5 -> same 3-cycle stall. A reader of an unwritten register -> no stall.
- ex_jump=1 while ID holds id_halt -> ifid_flush=idex_bubble=pc_we=1 and state stays RUN (halt discarded).
- id_halt in RUN -> DRAIN for 3 cycles, halted=1 on the 4th cycle. Pulse rst mid-DRAIN -> RUN with pc_we=1 on the next cycle.
- ex_overflow together with a pending hazard -> exmem_kill=1 and ifid_flush=1; halted=1 4 cycles later; stall_cycles unchanged.
